// File: rtl/cpu_ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package cpu_ifetch_pkg;

  localparam logic [31:0] RESET_ADDR_DEFAULT = 32'hFFFF0000;

  // Event encoding fed to the performance counter block.
  typedef enum logic [3:0] {
    PERF_NONE         = 4'd0,
    PERF_FETCH        = 4'd1,
    PERF_FETCH_STARVE = 4'd2
  } perf_event_e;

  // One prefetch FIFO entry: instruction word and the address it came from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// Register-based prefetch FIFO with synchronous clear; the head entry is read
// straight from storage so downstream logic sees no path from the push side.
module cpu_ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign head_data = mem[rd_ptr];

  // Storage: data registers carry no reset, only written on a live push.
  always_ff @(posedge clock) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; clear wins over any push or pop that cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  overflow_chk: assert property (@(posedge clock) disable iff (!reset)
    !(push && !pop && !clear && (count == CNT_W'(DEPTH))));

  underflow_chk: assert property (@(posedge clock) disable iff (!reset)
    !(pop && !clear && (count == '0)));

endmodule

// File: rtl/cpu_ifetch.sv
// Instruction fetch: credit-limited word requests, in-order response capture
// into a prefetch FIFO, and flush/redirect on a taken jump from the ALU stage.
module cpu_ifetch
  import cpu_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEFAULT,
  parameter int          DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_request,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        p2_valid,
  input  logic        p2_ready,
  output logic [31:0] p2_instr,
  output logic [31:0] p2_pc,
  input  logic        p4_jump,
  input  logic [31:0] p4_jump_target,
  output logic        fetch_starved
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      jump_pc;
  logic [CNT_W-1:0] inflight_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             accept;
  logic             keep;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic             unused_tgt_bits;

  assign unused_tgt_bits = ^p4_jump_target[1:0];
  assign jump_pc         = word_align(p4_jump_target);

  // Stale requests still hold credit, so refetch after a jump can be throttled.
  assign credit_used  = {1'b0, inflight_cnt} + {1'b0, fifo_count};
  assign imem_request = reset && !p4_jump && (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_addr    = fetch_pc;
  assign accept       = imem_request && imem_ready;

  assign keep         = imem_rvalid && !p4_jump && (drop_cnt == '0);
  assign pop          = p2_valid && p2_ready && !p4_jump;

  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = imem_rdata;

  assign p2_valid = (fifo_count != '0);
  assign p2_instr = head_entry.instr;
  assign p2_pc    = head_entry.pc;

  cpu_ifetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .clear     (p4_jump),
    .push      (keep),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  // Request address: redirect on jump, otherwise advance per accepted request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_ADDR;
    end else if (p4_jump) begin
      fetch_pc <= jump_pc;
    end else if (accept) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // Response PC tracks the address of the next response that will be kept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_pc <= RESET_ADDR;
    end else if (p4_jump) begin
      resp_pc <= jump_pc;
    end else if (keep) begin
      resp_pc <= resp_pc + 32'd4;
    end
  end

  // Outstanding requests: every response retires one, stale or not.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_cnt <= '0;
    end else begin
      inflight_cnt <= inflight_cnt + CNT_W'(accept) - CNT_W'(imem_rvalid);
    end
  end

  // Responses to discard: on a jump everything still outstanding goes stale.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if (p4_jump) begin
      drop_cnt <= inflight_cnt - CNT_W'(imem_rvalid);
    end else if (imem_rvalid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // Decoder waited on us with nothing to give and no redirect in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_starved <= 1'b0;
    end else begin
      fetch_starved <= p2_ready && !p2_valid && !p4_jump;
    end
  end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Directed bench for cpu_ifetch: per-cycle vector table for start-up and
// back-pressure, plus hand sequences for jumps and mid-burst reset.
module tb_cpu_ifetch;

  logic        clock;
  logic        reset;
  logic        imem_request;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        p2_valid;
  logic        p2_ready;
  logic [31:0] p2_instr;
  logic [31:0] p2_pc;
  logic        p4_jump;
  logic [31:0] p4_jump_target;
  logic        fetch_starved;

  cpu_ifetch #(
    .RESET_ADDR (32'hFFFF0000),
    .DEPTH      (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_request   (imem_request),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .p2_valid       (p2_valid),
    .p2_ready       (p2_ready),
    .p2_instr       (p2_instr),
    .p2_pc          (p2_pc),
    .p4_jump        (p4_jump),
    .p4_jump_target (p4_jump_target),
    .fetch_starved  (fetch_starved)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    bit          rst_before;
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    bit          exp_fs;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] deliv[$];
  int          cyc;
  int          lat;
  int          checks;
  int          failures;
  vec_t        tbl[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    p2_ready       = 1'b0;
    p4_jump        = 1'b0;
    p4_jump_target = 32'h0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    mq.delete();
    deliv.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    cyc   = -1;
  endtask

  // One clock cycle: drive inputs and the memory model, then sample mid-cycle.
  task automatic step(input bit rdy, input bit jmp, input logic [31:0] tgt);
    @(posedge clock);
    #1;
    cyc++;
    p2_ready       = rdy;
    p4_jump        = jmp;
    p4_jump_target = tgt;
    imem_ready     = 1'b1;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].addr;
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #3;
    if (imem_request && imem_ready) mq.push_back('{addr: imem_addr, due: cyc + lat});
    if (p2_valid && p2_ready && !p4_jump) begin
      deliv.push_back(p2_pc);
      check("instr_eq_pc", p2_instr, p2_pc);
    end
  endtask

  task automatic check_seq(input string name, input logic [31:0] base, input int n);
    check({name, "_count_ok"}, 32'(deliv.size() >= n), 32'd1);
    foreach (deliv[i]) check({name, "_pc"}, deliv[i], base + 32'(4 * i));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    lat      = 1;
    cyc      = 0;

    // Start-up with a zero-wait memory and decoder always ready.
    tbl[0]  = '{1, 1, 1, 32'hFFFF0000, 0, 32'h0,        0};
    tbl[1]  = '{0, 1, 1, 32'hFFFF0004, 0, 32'h0,        1};
    tbl[2]  = '{0, 1, 1, 32'hFFFF0008, 1, 32'hFFFF0000, 1};
    tbl[3]  = '{0, 1, 1, 32'hFFFF000C, 1, 32'hFFFF0004, 0};
    tbl[4]  = '{0, 1, 1, 32'hFFFF0010, 1, 32'hFFFF0008, 0};
    tbl[5]  = '{0, 1, 1, 32'hFFFF0014, 1, 32'hFFFF000C, 0};
    // Decoder stalled: credits run out after four accepts, then drain.
    tbl[6]  = '{1, 0, 1, 32'hFFFF0000, 0, 32'h0,        0};
    tbl[7]  = '{0, 0, 1, 32'hFFFF0004, 0, 32'h0,        0};
    tbl[8]  = '{0, 0, 1, 32'hFFFF0008, 1, 32'hFFFF0000, 0};
    tbl[9]  = '{0, 0, 1, 32'hFFFF000C, 1, 32'hFFFF0000, 0};
    tbl[10] = '{0, 0, 0, 32'hFFFF0010, 1, 32'hFFFF0000, 0};
    tbl[11] = '{0, 0, 0, 32'hFFFF0010, 1, 32'hFFFF0000, 0};
    tbl[12] = '{0, 1, 0, 32'hFFFF0010, 1, 32'hFFFF0000, 0};
    tbl[13] = '{0, 1, 1, 32'hFFFF0010, 1, 32'hFFFF0004, 0};
    tbl[14] = '{0, 1, 1, 32'hFFFF0014, 1, 32'hFFFF0008, 0};
    tbl[15] = '{0, 1, 1, 32'hFFFF0018, 1, 32'hFFFF000C, 0};
    tbl[16] = '{0, 1, 1, 32'hFFFF001C, 1, 32'hFFFF0010, 0};

    reset = 1'b0;
    #2;
    check("reset_req", imem_request, 1'b0);
    check("reset_valid", p2_valid, 1'b0);
    check("reset_starved", fetch_starved, 1'b0);

    lat = 1;
    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      step(tbl[i].rdy, 1'b0, 32'h0);
      check($sformatf("tbl%0d_req", i), imem_request, tbl[i].exp_req);
      check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
      check($sformatf("tbl%0d_valid", i), p2_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check($sformatf("tbl%0d_pc", i), p2_pc, tbl[i].exp_pc);
      check($sformatf("tbl%0d_starved", i), fetch_starved, tbl[i].exp_fs);
      if (i == 11) check("full_fifo_count", 32'(dut.fifo_count), 32'd4);
    end

    // Jump with three requests in flight and nothing returned yet.
    lat = 4;
    do_reset();
    repeat (3) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h00001002);
    check("j1_req_blocked", imem_request, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    check("j1_valid_after", p2_valid, 1'b0);
    check("j1_drop_cnt", 32'(dut.drop_cnt), 32'd3);
    check("j1_refetch_addr", imem_addr, 32'h00001000);
    check("j1_refetch_req", imem_request, 1'b1);
    repeat (20) step(1'b1, 1'b0, 32'h0);
    check_seq("j1_seq", 32'h00001000, 6);

    // Jump while a response arrives and a head entry is waiting.
    lat = 3;
    do_reset();
    repeat (4) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h00002000);
    check("j2_head_present", p2_valid, 1'b1);
    check("j2_head_pc", p2_pc, 32'hFFFF0000);
    check("j2_rvalid_same_cycle", imem_rvalid, 1'b1);
    step(1'b1, 1'b0, 32'h0);
    check("j2_drop_cnt", 32'(dut.drop_cnt), 32'd2);
    check("j2_valid_after", p2_valid, 1'b0);
    repeat (20) step(1'b1, 1'b0, 32'h0);
    check_seq("j2_seq", 32'h00002000, 6);

    // Back-to-back jumps: only the second target survives.
    lat = 2;
    do_reset();
    repeat (3) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h00000100);
    step(1'b1, 1'b1, 32'h00000200);
    check("j3_drop_mid", 32'(dut.drop_cnt), 32'd1);
    check("j3_req_blocked", imem_request, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    check("j3_drop_cnt", 32'(dut.drop_cnt), 32'd0);
    check("j3_refetch_addr", imem_addr, 32'h00000200);
    check("j3_valid_after", p2_valid, 1'b0);
    repeat (20) step(1'b1, 1'b0, 32'h0);
    check_seq("j3_seq", 32'h00000200, 6);

    // Asynchronous reset in the middle of a burst with responses pending.
    lat = 3;
    do_reset();
    repeat (5) step(1'b1, 1'b0, 32'h0);
    check("r_pre_valid", p2_valid, 1'b1);
    @(posedge clock);
    #1;
    reset       = 1'b0;
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check("r_async_req", imem_request, 1'b0);
    check("r_async_valid", p2_valid, 1'b0);
    check("r_async_starved", fetch_starved, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 32'h0);
    check("r_restart_addr", imem_addr, 32'hFFFF0000);
    check("r_restart_req", imem_request, 1'b1);
    repeat (15) step(1'b1, 1'b0, 32'h0);
    check_seq("r_seq", 32'hFFFF0000, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_ifetch.md
Name: cpu_ifetch

Overview:
Instruction fetch stage. Issues word reads to instruction memory, buffers returned words with their PCs in a small prefetch FIFO, and presents them to the decoder over the p2_valid/p2_ready handshake. On a taken jump from the ALU stage (p4_jump), it flushes all buffered and in-flight instructions and restarts fetch at the jump target.

Parameters:
RESET_ADDR, 32'hFFFF0000, first fetch address after reset
DEPTH, 4, prefetch FIFO entries; also the maximum of buffered plus in-flight requests (power of 2, 2..8)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = in reset)
imem_request  output  1  read request valid
imem_addr  output  32  word address of request; bits [1:0] always 0
imem_ready  input  1  memory accepts request this cycle when high with imem_request
imem_rvalid  input  1  read data valid; responses return in order, at least 1 cycle after acceptance
imem_rdata  input  32  instruction word
p2_valid  output  1  p2_instr/p2_pc hold a valid instruction
p2_ready  input  1  decoder consumes the head entry
p2_instr  output  32  instruction word at FIFO head
p2_pc  output  32  address of p2_instr
p4_jump  input  1  taken jump or branch in ALU stage
p4_jump_target  input  32  new fetch address; bits [1:0] ignored
fetch_starved  output  1  registered: decoder ready, no valid instruction, no jump

Behaviour:
- Reset (reset=0, asynchronous) sets the following:
  - fetch_pc=RESET_ADDR; FIFO empty; inflight_cnt=0; drop_cnt=0.
  - imem_request=0, p2_valid=0, fetch_starved=0.
  - p2_instr and p2_pc are don't-care while p2_valid=0.
- imem_request is combinational. It is 1 when all of the following hold:
  - reset is released;
  - p4_jump=0;
  - inflight_cnt + fifo_count < DEPTH.
- imem_addr=fetch_pc. On acceptance (request and imem_ready): fetch_pc += 4 and inflight_cnt += 1.
- inflight_cnt decrements on every imem_rvalid, stale or not. Simultaneous accept and rvalid leave it unchanged.
- Response handling:
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise it is pushed to the FIFO with pc = resp_pc. resp_pc is a register that advances by 4 per kept response.
  - The credit rule guarantees a push never overflows. Overflow is an assertion failure.
- p2_valid = FIFO not empty. p2_instr/p2_pc come directly from the head entry's storage registers, so no combinational path runs from imem_* to p2_*.
- Pop happens when p2_valid && p2_ready && !p4_jump.
  - Push and pop in the same cycle keep the count.
  - Pop from a 1-entry FIFO with a simultaneous push gives p2_valid=1 next cycle with the new word.
- Jump cycle (p4_jump=1) has priority over everything:
  - FIFO cleared at the edge; no pop and no push.
  - fetch_pc <= {p4_jump_target[31:2],2'b00}; resp_pc <= same.
  - No request is issued this cycle.
  - drop_cnt <= inflight_cnt - imem_rvalid. Any response arriving this cycle is discarded. Every request still outstanding becomes stale, including those already counted in drop_cnt.
  - First request at the target goes out the cycle after the jump. p2_valid is 0 the cycle after the jump.
- Back-to-back jumps: each jump re-applies the rules above. The last target wins.
- The memory-level credit check counts stale in-flight requests. Refetch can therefore be throttled until stale responses drain.
- fetch_starved <= p2_ready && !p2_valid && !p4_jump (registered, for perf counters).
- Steady state: with a zero-wait memory (1-cycle response), one instruction per cycle is delivered to the decoder.

Decomposition:
- cpu.vh gains `RESET_ADDR default and the PERF_FETCH encoding used by the perf counter.
- One sub-module, cpu_ifetch_fifo. It is parameterised on DEPTH and WIDTH=64 ({pc,instr}), with a synchronous clear input, push/pop, a count output, and register-based head read.
- Credit and drop counters stay in cpu_ifetch. Both are $clog2(DEPTH)+1 bits wide.

Test Plan:
1. Reset release with zero-wait memory returning word = address → imem_addr sequence FFFF0000, FFFF0004, …; p2_valid first high 2 cycles after the first request; with p2_ready=1, one instruction per cycle with p2_pc=p2_instr.
2. Hold p2_ready=0 → after 4 accepts, imem_request=0 and fifo_count=4. Release p2_ready → entries drain in order FFFF0000..FFFF000C and requests resume.
3. Memory latency 3, 3 requests in flight, p4_jump=1 with target 0x00001002 → the 3 stale responses are discarded; next p2_pc=0x00001000; no stale PC ever appears on p2.
4. Jump in the same cycle as an imem_rvalid and with p2_ready=1 → that response and the head entry are both dropped; drop_cnt = inflight-1.
5. Two jumps on consecutive cycles (targets 0x100, then 0x200) with latency 2 → only 0x200-onward instructions are delivered.
6. Assert reset=0 mid-burst with responses pending → outputs clear immediately (asynchronously); after release, fetch restarts at FFFF0000. The bench must not return responses for pre-reset requests.
